// File: rtl/mux16_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mux16_rr_arbiter
//  Purpose  : Round-robin arbiter/sequencer for a shared 16:1 data mux.
//             Grants one requester at a time and drives the mux select.
//             A grant is held until done, until the owner withdraws its
//             request, or until the hold limit forces a release.
//             One dead cycle separates consecutive owners.
//  Revision : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter #(
  parameter int N        = 16,
  parameter int SELW     = 4,
  parameter int MAX_HOLD = 8,
  parameter int HCW      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [SELW-1:0] select,
  output logic [N-1:0]    grant,
  output logic            gnt_valid,
  output logic            timeout,
  output logic [SELW-1:0] ptr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Last hold-counter value of a grant before a forced release.
  localparam logic [HCW-1:0] c_hold_last = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
  localparam logic [N-1:0]   c_one       = {{(N-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [SELW-1:0] r_select;
  logic [N-1:0]    r_grant;
  logic            r_gnt_valid;
  logic            r_timeout;
  logic [SELW-1:0] r_ptr;
  logic [HCW-1:0]  r_hold_cnt;

  logic [SELW-1:0] w_winner;
  logic [SELW-1:0] w_idx;
  logic            w_found;
  logic            w_any_req;
  logic            w_owner_req;
  logic            w_hold_expired;
  logic            w_release;

  // Rotating-priority scan: first requester at or after ptr wins.
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = r_ptr + SELW'(k);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    w_any_req      = |req;
    w_owner_req    = req[r_select];
    w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);
    w_release      = done || !w_owner_req || w_hold_expired;
  end

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_select    <= '0;
      r_grant     <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          r_grant     <= '0;
          r_gnt_valid <= 1'b0;
          if (w_any_req) begin
            r_select    <= w_winner;
            r_grant     <= c_one << w_winner;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= ST_GRANT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_grant     <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_select + SELW'(1);
            // Timeout only when neither done nor withdrawal caused the release.
            r_timeout   <= !done && w_owner_req;
            r_state     <= ST_GAP;
          end else if (r_hold_cnt != {HCW{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + HCW'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_grant     <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign select    = r_select;
  assign grant     = r_grant;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;
  assign ptr       = r_ptr;

endmodule
`default_nettype wire
